mask_beat_streamer: RTL and testbench
=====================================

// Module: mask_beat_streamer
// PURPOSE
//   Far end of the green-filter mask interface. Accepts a full HEIGHT x LENGTH binary mask
//   (1 = non-green, 0 = green) in one valid/ready transfer and latches it internally.
//   It then serialises the mask into BEAT_W-bit beats on a valid/ready stream.
//   The neural-net input stage consumes that stream.
// PARAMETERS
//   HEIGHT   32  mask rows
//   LENGTH   32  mask columns
//   BEAT_W   16  bits per output beat (1..HEIGHT*LENGTH)
//   Derived: NPIX = HEIGHT*LENGTH; NBEATS = ceil(NPIX/BEAT_W); CW = $clog2(NBEATS+1)
// PORTS
//   clk          in   1               rising-edge clock
//   rst          in   1               synchronous, active-high reset
//   mask_in      in   HEIGHT*LENGTH   packed mask; pixel (r,c) at bit r*LENGTH+c
//   mask_valid   in   1               mask_in valid
//   mask_ready   out  1               block can accept a frame
//   out_data     out  BEAT_W          beat k bit b = pixel k*BEAT_W+b; bits >= NPIX read 0
//   out_valid    out  1               out_data valid
//   out_ready    in   1               downstream accepts beat
//   out_first    out  1               beat index == 0 (qualified by out_valid)
//   out_last     out  1               beat index == NBEATS-1 (qualified by out_valid)
//   out_idx      out  CW              current beat index
//   frame_done   out  1               1-cycle pulse after last beat accepted
//   fg_count     out  $clog2(NPIX+1)  ones in frame (MASK_POPCOUNT_EN only)
// BEHAVIOUR
//   - Reset values: mask_ready=0 in reset cycle, then 1. out_valid=0, out_first=0,
//     out_last=0, out_idx=0, frame_done=0, fg_count=0, frame store cleared.
//   - FSM IDLE -> SEND -> (DONE) -> IDLE.
//   - IDLE: mask_ready=1, out_valid=0. On mask_valid&&mask_ready, latch mask_in,
//     set idx=0, go to SEND.
//   - SEND: mask_ready=0, out_valid=1. Latency: frame accepted in cycle N gives beat 0
//     valid in cycle N+1.
//   - Beat transfer occurs when out_valid&&out_ready; idx increments the next cycle.
//   - While out_valid&&!out_ready: out_data, out_idx, out_first and out_last hold stable.
//   - Last beat (idx==NBEATS-1) transfers: go to DONE. out_valid=0 next cycle and
//     frame_done=1 for that one cycle. DONE -> IDLE unconditionally next cycle.
//   - Minimum frame period: NBEATS+2 cycles.
//   - NBEATS==1: out_first and out_last are both 1 on the single beat.
//   - Partial last beat: upper BEAT_W*NBEATS-NPIX bits are 0; no keep signal.
//   - mask_valid during SEND/DONE is ignored. The upstream holds the frame (mask_ready=0).
//   - rst mid-frame: abort immediately, drop the stored frame, no frame_done, return to IDLE.
//   - out_ready is sampled only while out_valid=1.
// CONFIGURATION
//   MASK_POPCOUNT_EN defined:
//     - fg_count clears to 0 on frame accept.
//     - On each beat transfer it adds the popcount of that beat (padding bits are 0).
//     - Final value is valid when frame_done=1 and holds until the next frame accept.
//   MASK_POPCOUNT_EN undefined: fg_count port present, tied to 0; no adder logic.
// TESTING (HEIGHT=4, LENGTH=5, BEAT_W=8 -> NPIX=20, NBEATS=3)
//   1. mask_in=20'hA5C3F, out_ready=1 -> beats 8'h3F, 8'h5C, 8'h0A; first on idx0,
//      last on idx2; frame_done 1 cycle after beat 2; mask_ready back 1 cycle later.
//   2. Same frame; out_ready=0 for 3 cycles at idx1 -> 8'h5C held stable, idx=1;
//      nothing skipped or duplicated.
//   3. mask_valid held high continuously -> each frame accepted only in IDLE;
//      period = 5 cycles with out_ready=1.
//   4. rst asserted during idx1 -> next cycle out_valid=0 and mask_ready=1; no frame_done.
//      A new frame then streams from idx0.
//   5. MASK_POPCOUNT_EN, mask_in=20'hFFFFF -> fg_count=20 at frame_done.
//      Next frame 20'h00001 -> 0 after accept, 1 at frame_done.
//   6. HEIGHT=2, LENGTH=4, BEAT_W=8 (NBEATS=1), mask_in=8'hC3 -> single beat 8'hC3
//      with out_first=out_last=1.

Source files
------------

// File: rtl/mask_beat_streamer.sv
// mask_beat_streamer: latches a HEIGHT x LENGTH binary mask in one valid/ready
// transfer, then streams it out as BEAT_W-bit beats (LSB pixel first).
// Optional feature macro: MASK_POPCOUNT_EN (running count of set mask pixels on fg_count_o).
module mask_beat_streamer #(
    parameter int HEIGHT = 32,
    parameter int LENGTH = 32,
    parameter int BEAT_W = 16,
    localparam int NPIX   = HEIGHT * LENGTH,
    localparam int NBEATS = (NPIX + BEAT_W - 1) / BEAT_W,
    localparam int CW     = $clog2(NBEATS + 1),
    localparam int FW     = $clog2(NPIX + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NPIX-1:0]   mask_in_i,
    input  logic              mask_valid_i,
    output logic              mask_ready_o,
    output logic [BEAT_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_first_o,
    output logic              out_last_o,
    output logic [CW-1:0]     out_idx_o,
    output logic              frame_done_o,
    output logic [FW-1:0]     fg_count_o
);

    // Frame store is padded to a whole number of beats; padding bits stay 0.
    localparam int SW = NBEATS * BEAT_W;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   frame_q;
    logic [CW-1:0]   idx_q;
    logic            out_valid_q;
    logic            out_first_q;
    logic            out_last_q;
    logic            done_q;

    logic            accept;
    logic            fire;
    logic [CW-1:0]   idx_d;

    // Ready is held low while reset is asserted so no frame slips in on the reset edge.
    assign mask_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept       = mask_ready_o && mask_valid_i;
    assign fire         = out_valid_q && out_ready_i;
    assign idx_d        = idx_q + 1'b1;

    // The current beat always sits in the low bits of the store, which shifts per beat.
    assign out_data_o   = frame_q[BEAT_W-1:0];
    assign out_valid_o  = out_valid_q;
    assign out_first_o  = out_first_q;
    assign out_last_o   = out_last_q;
    assign out_idx_o    = idx_q;
    assign frame_done_o = done_q;

    // Frame FSM: accept in IDLE, stream beats in SEND, one-cycle DONE pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        frame_q     <= SW'(mask_in_i);
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b1;
                        out_last_q  <= (NBEATS == 1);
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q       <= idx_d;
                            frame_q     <= frame_q >> BEAT_W;
                            out_first_q <= 1'b0;
                            out_last_q  <= (idx_d == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MASK_POPCOUNT_EN
    logic [FW-1:0] fg_q;

    function automatic logic [FW-1:0] beat_ones(input logic [BEAT_W-1:0] b);
        logic [FW-1:0] n;
        n = '0;
        for (int i = 0; i < BEAT_W; i++) begin
            n = n + FW'(b[i]);
        end
        return n;
    endfunction

    // Running popcount: cleared on frame accept, accumulates each transferred beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fg_q <= '0;
        end else if (accept) begin
            fg_q <= '0;
        end else if (fire) begin
            fg_q <= fg_q + beat_ones(out_data_o);
        end
    end

    assign fg_count_o = fg_q;
`else
    assign fg_count_o = '0;
`endif

endmodule

// File: tb/tb_mask_beat_streamer.sv
// Randomized self-checking bench for mask_beat_streamer (4x5 mask, 8-bit beats)
// plus a single-beat instance (2x4 mask, 8-bit beats).
module tb_mask_beat_streamer;

    localparam int NPIX = 20;
    localparam int NB   = 3;
`ifdef MASK_POPCOUNT_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, mask_valid, out_ready;
    logic [19:0] mask_in;
    logic [7:0]  out_data;
    logic        mask_ready, out_valid, out_first, out_last, frame_done;
    logic [1:0]  out_idx;
    logic [4:0]  fg_count;

    // single-beat instance
    logic        rst1, mv1, or1;
    logic [7:0]  mi1, od1;
    logic        mr1, ov1, f1, l1, fd1;
    logic [0:0]  idx1;
    logic [3:0]  fg1;

    int checks = 0;
    int errors = 0;

    mask_beat_streamer #(.HEIGHT(4), .LENGTH(5), .BEAT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .mask_in_i(mask_in), .mask_valid_i(mask_valid),
        .mask_ready_o(mask_ready), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_first_o(out_first), .out_last_o(out_last),
        .out_idx_o(out_idx), .frame_done_o(frame_done), .fg_count_o(fg_count)
    );

    mask_beat_streamer #(.HEIGHT(2), .LENGTH(4), .BEAT_W(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .mask_in_i(mi1), .mask_valid_i(mv1),
        .mask_ready_o(mr1), .out_data_o(od1), .out_valid_o(ov1),
        .out_ready_i(or1), .out_first_o(f1), .out_last_o(l1),
        .out_idx_o(idx1), .frame_done_o(fd1), .fg_count_o(fg1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // beat k of a mask = bits [8k, 8k+8) of the zero-extended mask
    function automatic logic [7:0] beat_of(input logic [19:0] m, input int k);
        logic [23:0] p;
        p = {4'b0, m} >> (8 * k);
        return p[7:0];
    endfunction

    // ones among pixels already delivered in the first k beats
    function automatic int expfg(input logic [19:0] m, input int k);
        int n;
        n = 0;
        if (!PC) return 0;
        for (int i = 0; i < NPIX; i++)
            if (i < 8 * k && m[i]) n++;
        return n;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: 3-cycle stall at idx1; 2: random ready
    task automatic run_frame(input logic [19:0] m, input int mode);
        int k, stall, cyc;
        logic rdy;
        chk("idle_rdy", mask_ready, 1);
        chk("idle_vld", out_valid, 0);
        mask_in = m;
        mask_valid = 1'b1;
        step;
        mask_valid = 1'b0;
        mask_in = 20'($urandom);
        k = 0; stall = 0; cyc = 0;
        while (k < NB && cyc < 100) begin
            chk("vld", out_valid, 1);
            chk("idx", out_idx, k);
            chk("data", out_data, beat_of(m, k));
            chk("first", out_first, k == 0);
            chk("last", out_last, k == NB - 1);
            chk("mrdy_busy", mask_ready, 0);
            chk("fg_run", fg_count, expfg(m, k));
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = !(k == 1 && stall < 3);
                    if (!rdy) stall++;
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            step;
            if (rdy) k++;
            cyc++;
        end
        chk("beat_tmo", k, NB);
        out_ready = 1'($urandom_range(0, 1));
        chk("done_vld", out_valid, 0);
        chk("done_pulse", frame_done, 1);
        chk("fg_final", fg_count, expfg(m, NB));
        chk("done_mrdy", mask_ready, 0);
        step;
        chk("done_clr", frame_done, 0);
        chk("back_rdy", mask_ready, 1);
        chk("fg_hold", fg_count, expfg(m, NB));
    endtask

    initial begin
        logic [19:0] acc;
        logic [19:0] m;
        logic [7:0]  s;
        int p;
        rst = 1'b1; mask_valid = 1'b0; out_ready = 1'b0; mask_in = '0;
        rst1 = 1'b1; mv1 = 1'b0; or1 = 1'b0; mi1 = '0;
        acc = '0;
        step;
        chk("rst_mrdy", mask_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_fg", fg_count, 0);
        rst = 1'b0; rst1 = 1'b0;
        #1;
        chk("post_rst_mrdy", mask_ready, 1);

        // directed frame, then stalled frame
        run_frame(20'hA5C3F, 0);
        run_frame(20'hA5C3F, 1);
        // popcount extremes
        run_frame(20'hFFFFF, 0);
        run_frame(20'h00001, 0);
        // random frames with random back-pressure
        repeat (10) run_frame(20'($urandom), 2);

        // mask_valid held high: one accept per 5 cycles, mask_in churn ignored
        mask_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            mask_in = 20'($urandom);
            p = i % 5;
            chk("hold_mrdy", mask_ready, p == 0);
            chk("hold_vld", out_valid, p >= 1 && p <= 3);
            chk("hold_done", frame_done, p == 4);
            if (p == 0) acc = mask_in;
            else if (p <= 3) chk("hold_data", out_data, beat_of(acc, p - 1));
            step;
        end
        mask_valid = 1'b0;

        // reset mid-frame at idx1
        m = 20'($urandom);
        mask_in = m; mask_valid = 1'b1;
        step;
        mask_valid = 1'b0; out_ready = 1'b1;
        step;
        chk("abort_idx", out_idx, 1);
        rst = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("abort_rst_mrdy", mask_ready, 0);
        step;
        rst = 1'b0;
        #1;
        chk("abort_vld", out_valid, 0);
        chk("abort_mrdy", mask_ready, 1);
        chk("abort_done", frame_done, 0);
        chk("abort_idx0", out_idx, 0);
        step;
        chk("abort_nodone", frame_done, 0);
        run_frame(20'($urandom), 0);

        // single-beat instance
        for (int i = 0; i < 4; i++) begin
            s = (i == 0) ? 8'hC3 : 8'($urandom);
            chk("sb_mrdy", mr1, 1);
            mi1 = s; mv1 = 1'b1; or1 = 1'b0;
            step;
            mv1 = 1'b0;
            chk("sb_vld", ov1, 1);
            chk("sb_data", od1, s);
            chk("sb_first", f1, 1);
            chk("sb_last", l1, 1);
            chk("sb_idx", idx1, 0);
            step;
            chk("sb_hold", od1, s);
            chk("sb_hold_vld", ov1, 1);
            or1 = 1'b1;
            step;
            or1 = 1'b0;
            chk("sb_done_vld", ov1, 0);
            chk("sb_done", fd1, 1);
            step;
            chk("sb_done_clr", fd1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
